// File: rtl/csi_lane_aligner.sv
// rtl/csi_lane_aligner.sv - per-lane CSI byte deskew into lane-aligned words
//
// Purpose
//   Each CSI data lane delivers bytes with its own valid strobe. Every lane
//   has a small skew FIFO. When all FIFOs hold at least one byte, their heads
//   are popped together and registered as one NUM_LANE*8-bit word, so every
//   byte of the word belongs to the same CSI byte slot. If lanes stay
//   partially filled for MAX_SKEW cycles, all FIFOs are flushed and err_skew
//   pulses.
//
// Ports
//   clk           in   1             pixel-byte clock; the only clock
//   rst_n         in   1             synchronous reset, active-low
//   in_vld        in   NUM_LANE      per-lane byte strobe (lane_vld_t)
//   in_data       in   NUM_LANE*8    per-lane byte, lane i at [8i+7:8i] (lane_data_t)
//   out_vld       out  1             aligned word valid
//   out_data      out  NUM_LANE*8    aligned word, lane i at [8i+7:8i] (lane_mem_t)
//   aligned       out  1             high while the FSM is in ALIGNED
//   err_skew      out  1             1-cycle pulse, the cycle after a skew flush
//   err_ovf       out  1             1-cycle pulse, the cycle after a byte is dropped
//   skew_err_cnt  out  16            saturating err_skew count (CSI_ALIGN_STATS_EN only)
//   ovf_err_cnt   out  16            saturating err_ovf count (CSI_ALIGN_STATS_EN only)
//
// Configuration
//   CSI_ALIGN_STATS_EN  when defined, adds skew_err_cnt / ovf_err_cnt.

package top_pkg;
  localparam int NUM_LANE = 4;
  typedef logic [NUM_LANE-1:0]   lane_vld_t;
  typedef logic [NUM_LANE*8-1:0] lane_data_t;
  typedef logic [NUM_LANE*8-1:0] lane_mem_t;
endpackage

module csi_lane_aligner #(
  parameter int NUM_LANE   = top_pkg::NUM_LANE,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_SKEW   = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_LANE-1:0]   in_vld,
  input  logic [NUM_LANE*8-1:0] in_data,
  output logic                  out_vld,
  output logic [NUM_LANE*8-1:0] out_data,
  output logic                  aligned,
  output logic                  err_skew,
  output logic                  err_ovf
`ifdef CSI_ALIGN_STATS_EN
  ,
  output logic [15:0]           skew_err_cnt,
  output logic [15:0]           ovf_err_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(MAX_SKEW + 1);
  localparam logic [SW-1:0] SKEW_MAX = SW'(MAX_SKEW);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ALIGNED,
    ST_FLUSH
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         skew_cnt_q, skew_cnt_d;
  logic [PW-1:0]         wr_ptr_q [NUM_LANE];
  logic [PW-1:0]         wr_ptr_d [NUM_LANE];
  logic [PW-1:0]         rd_ptr_q [NUM_LANE];
  logic [PW-1:0]         rd_ptr_d [NUM_LANE];
  logic [7:0]            mem_q [NUM_LANE][FIFO_DEPTH];
  logic [7:0]            mem_d [NUM_LANE][FIFO_DEPTH];
  logic                  out_vld_q, out_vld_d;
  logic [NUM_LANE*8-1:0] out_data_q, out_data_d;
  logic                  err_skew_q, err_skew_d;
  logic                  err_ovf_q, err_ovf_d;

  logic [NUM_LANE-1:0]   empty;
  logic [NUM_LANE-1:0]   full;
  logic                  all_ne;
  logic                  all_e;
  logic                  pop;
  logic                  flush;
  logic [NUM_LANE*8-1:0] head_word;

  // FIFO status from the wrap-bit pointers.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
    end
  end

  assign all_ne = ~|empty;
  assign all_e  = &empty;
  assign flush  = (state_q == ST_FLUSH);
  assign pop    = all_ne && !flush;

  // FIFO write/pop and the registered output word.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    head_word  = '0;
    err_ovf_d  = 1'b0;
    for (int i = 0; i < NUM_LANE; i++) begin
      head_word[8*i +: 8] = mem_q[i][rd_ptr_q[i][AW-1:0]];
      if (flush) begin
        // Flush drops everything, including bytes arriving this cycle.
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
      end else begin
        if (pop) begin
          rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
        end
        if (in_vld[i]) begin
          // A full FIFO that pops this cycle frees exactly the slot being
          // written (its head), so the byte is kept.
          if (!full[i] || pop) begin
            mem_d[i][wr_ptr_q[i][AW-1:0]] = in_data[8*i +: 8];
            wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
          end else begin
            err_ovf_d = 1'b1;
          end
        end
      end
    end
    out_vld_d  = pop;
    out_data_d = pop ? head_word : out_data_q;
    err_skew_d = flush;
  end

  // Alignment FSM and skew timer.
  always_comb begin
    state_d    = state_q;
    skew_cnt_d = skew_cnt_q;
    case (state_q)
      ST_IDLE: begin
        skew_cnt_d = '0;
        if (all_ne) begin
          state_d = ST_ALIGNED;
        end else if (!all_e) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (all_ne) begin
          state_d    = ST_ALIGNED;
          skew_cnt_d = '0;
        end else if (all_e) begin
          state_d = ST_IDLE;
        end else if (skew_cnt_q == SKEW_MAX) begin
          state_d = ST_FLUSH;
        end else begin
          skew_cnt_d = skew_cnt_q + SW'(1);
        end
      end
      ST_ALIGNED: begin
        if (all_ne) begin
          skew_cnt_d = '0;
        end else if (all_e) begin
          // Empty FIFOs with bytes still arriving is just a bubble; only an
          // idle link ends the packet.
          if (in_vld == '0) begin
            state_d = ST_IDLE;
          end
        end else if (skew_cnt_q == SKEW_MAX) begin
          state_d = ST_FLUSH;
        end else begin
          skew_cnt_d = skew_cnt_q + SW'(1);
        end
      end
      ST_FLUSH: begin
        state_d    = ST_IDLE;
        skew_cnt_d = '0;
      end
      default: begin
        state_d    = ST_IDLE;
        skew_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      skew_cnt_q <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      err_skew_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      for (int i = 0; i < NUM_LANE; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      skew_cnt_q <= skew_cnt_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      err_skew_q <= err_skew_d;
      err_ovf_q  <= err_ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign aligned  = (state_q == ST_ALIGNED);
  assign err_skew = err_skew_q;
  assign err_ovf  = err_ovf_q;

`ifdef CSI_ALIGN_STATS_EN
  logic [15:0] skew_err_cnt_q, skew_err_cnt_d;
  logic [15:0] ovf_err_cnt_q, ovf_err_cnt_d;

  // Counted on the _d pulses so a count moves in the same cycle as its pulse.
  always_comb begin
    skew_err_cnt_d = skew_err_cnt_q;
    ovf_err_cnt_d  = ovf_err_cnt_q;
    if (err_skew_d && (skew_err_cnt_q != 16'hFFFF)) begin
      skew_err_cnt_d = skew_err_cnt_q + 16'd1;
    end
    if (err_ovf_d && (ovf_err_cnt_q != 16'hFFFF)) begin
      ovf_err_cnt_d = ovf_err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skew_err_cnt_q <= '0;
      ovf_err_cnt_q  <= '0;
    end else begin
      skew_err_cnt_q <= skew_err_cnt_d;
      ovf_err_cnt_q  <= ovf_err_cnt_d;
    end
  end

  assign skew_err_cnt = skew_err_cnt_q;
  assign ovf_err_cnt  = ovf_err_cnt_q;
`endif

endmodule

// File: tb/tb_csi_lane_aligner.sv
// tb/tb_csi_lane_aligner.sv - self-checking bench for csi_lane_aligner
module tb_csi_lane_aligner;

  localparam int NL    = 4;
  localparam int DEPTH = 8;
  localparam int MS0   = 7;
  localparam int MS1   = 20;

  localparam int S_IDLE    = 0;
  localparam int S_WAIT    = 1;
  localparam int S_ALIGNED = 2;
  localparam int S_FLUSH   = 3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_vld;
  logic [31:0] in_data;
  logic        o_vld   [2];
  logic [31:0] o_data  [2];
  logic        o_align [2];
  logic        o_eskew [2];
  logic        o_eovf  [2];
`ifdef CSI_ALIGN_STATS_EN
  logic [15:0] o_scnt  [2];
  logic [15:0] o_ocnt  [2];
`endif

  csi_lane_aligner #(.NUM_LANE(NL), .FIFO_DEPTH(DEPTH), .MAX_SKEW(MS0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data),
    .out_vld(o_vld[0]), .out_data(o_data[0]), .aligned(o_align[0]),
    .err_skew(o_eskew[0]), .err_ovf(o_eovf[0])
`ifdef CSI_ALIGN_STATS_EN
    , .skew_err_cnt(o_scnt[0]), .ovf_err_cnt(o_ocnt[0])
`endif
  );

  csi_lane_aligner #(.NUM_LANE(NL), .FIFO_DEPTH(DEPTH), .MAX_SKEW(MS1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data),
    .out_vld(o_vld[1]), .out_data(o_data[1]), .aligned(o_align[1]),
    .err_skew(o_eskew[1]), .err_ovf(o_eovf[1])
`ifdef CSI_ALIGN_STATS_EN
    , .skew_err_cnt(o_scnt[1]), .ovf_err_cnt(o_ocnt[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-lane byte lists (head at index 0), mode, skew timer.
  logic [7:0]  m_mem [2][NL][DEPTH];
  int          m_cnt [2][NL];
  int          m_st  [2];
  int          m_skew[2];
  int          ms    [2];
  logic        m_vld [2];
  logic [31:0] m_data[2];
  logic        m_eskew[2];
  logic        m_eovf [2];
  int          m_cs  [2];
  int          m_co  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rep4(input logic [7:0] b);
    return {b, b, b, b};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = S_IDLE; m_skew[k] = 0;
      m_vld[k] = 1'b0; m_data[k] = '0;
      m_eskew[k] = 1'b0; m_eovf[k] = 1'b0;
      m_cs[k] = 0; m_co[k] = 0;
      for (int i = 0; i < NL; i++) m_cnt[k][i] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] v, input logic [31:0] d);
    bit all_ne, all_e, flush, pop, ovf;
    logic [31:0] w;
    all_ne = 1; all_e = 1; ovf = 0; w = '0;
    for (int i = 0; i < NL; i++) begin
      if (m_cnt[k][i] == 0) all_ne = 0;
      else all_e = 0;
    end
    flush = (m_st[k] == S_FLUSH);
    pop   = all_ne && !flush;
    if (pop) begin
      for (int i = 0; i < NL; i++) begin
        w[8*i +: 8] = m_mem[k][i][0];
        for (int j = 0; j < DEPTH-1; j++) m_mem[k][i][j] = m_mem[k][i][j+1];
        m_cnt[k][i]--;
      end
    end
    for (int i = 0; i < NL; i++) begin
      if (flush) m_cnt[k][i] = 0;
      else if (v[i]) begin
        if (m_cnt[k][i] < DEPTH) begin
          m_mem[k][i][m_cnt[k][i]] = d[8*i +: 8];
          m_cnt[k][i]++;
        end else ovf = 1;
      end
    end
    m_vld[k] = pop;
    if (pop) m_data[k] = w;
    m_eskew[k] = flush;
    m_eovf[k]  = ovf;
    if (flush && m_cs[k] < 65535) m_cs[k]++;
    if (ovf && m_co[k] < 65535) m_co[k]++;
    case (m_st[k])
      S_IDLE: begin
        m_skew[k] = 0;
        if (all_ne) m_st[k] = S_ALIGNED;
        else if (!all_e) m_st[k] = S_WAIT;
      end
      S_WAIT: begin
        if (all_ne) begin m_st[k] = S_ALIGNED; m_skew[k] = 0; end
        else if (all_e) m_st[k] = S_IDLE;
        else if (m_skew[k] == ms[k]) m_st[k] = S_FLUSH;
        else m_skew[k]++;
      end
      S_ALIGNED: begin
        if (all_ne) m_skew[k] = 0;
        else if (all_e) begin
          if (v == 4'b0) m_st[k] = S_IDLE;
        end
        else if (m_skew[k] == ms[k]) m_st[k] = S_FLUSH;
        else m_skew[k]++;
      end
      default: begin m_st[k] = S_IDLE; m_skew[k] = 0; end
    endcase
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d out_vld", k),  {31'b0, o_vld[k]},   {31'b0, m_vld[k]});
      chk($sformatf("dut%0d out_data", k), o_data[k],           m_data[k]);
      chk($sformatf("dut%0d aligned", k),  {31'b0, o_align[k]}, {31'b0, m_st[k] == S_ALIGNED});
      chk($sformatf("dut%0d err_skew", k), {31'b0, o_eskew[k]}, {31'b0, m_eskew[k]});
      chk($sformatf("dut%0d err_ovf", k),  {31'b0, o_eovf[k]},  {31'b0, m_eovf[k]});
`ifdef CSI_ALIGN_STATS_EN
      chk($sformatf("dut%0d skew_err_cnt", k), {16'b0, o_scnt[k]}, 32'(m_cs[k]));
      chk($sformatf("dut%0d ovf_err_cnt", k),  {16'b0, o_ocnt[k]}, 32'(m_co[k]));
`endif
    end
  endtask

  // One clock cycle: drive, compare at negedge, advance model and DUT.
  // On return the DUT outputs show the following cycle.
  task automatic tick(input logic [3:0] v, input logic [31:0] d);
    in_vld = v; in_data = d;
    @(negedge clk);
    check_all();
    model_step(0, v, d);
    model_step(1, v, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] v);
    rst_n = 1'b0; in_vld = v; in_data = $urandom;
    @(negedge clk);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  // Lane1 gets 9 bytes alone (9th dropped), then the other lanes catch up
  // so lane1's kept bytes drain aligned.
  task automatic run_ovf(input bit directed);
    logic [31:0] d;
    logic [3:0]  v;
    for (int c = 0; c < 20; c++) begin
      v = 4'b0; d = '0;
      if (c <= 8) begin v[1] = 1'b1; d[15:8] = 8'hA0 + 8'(c); end
      if (c >= 8 && c <= 15) begin
        v[0] = 1'b1; v[2] = 1'b1; v[3] = 1'b1;
        d[7:0] = 8'h50 + 8'(c-8); d[23:16] = 8'h50 + 8'(c-8); d[31:24] = 8'h50 + 8'(c-8);
      end
      tick(v, d);
      if (directed) begin
        chk($sformatf("ovf err_ovf c%0d", c+1), {31'b0, o_eovf[0]}, {31'b0, (c+1) == 9});
        chk($sformatf("ovf out_vld c%0d", c+1), {31'b0, o_vld[0]}, {31'b0, (c+1) >= 10 && (c+1) <= 17});
        if ((c+1) >= 10 && (c+1) <= 17)
          chk($sformatf("ovf word c%0d", c+1), o_data[0],
              {8'h50 + 8'(c-9), 8'h50 + 8'(c-9), 8'hA0 + 8'(c-9), 8'h50 + 8'(c-9)});
      end
    end
  endtask

  task automatic run_timeout(input int nbytes, input int span);
    for (int c = 0; c < span; c++)
      tick((c < nbytes) ? 4'b0100 : 4'b0000, {8'h0, 8'hE0 + 8'(c), 16'h0});
  endtask

  initial begin
    int off[NL];
    int len[NL];
    int span;
    int nsk;
    int nv;
    bit same;
    logic [3:0]  v;
    logic [31:0] d;

    ms[0] = MS0; ms[1] = MS1;
    rst_n = 1'b0; in_vld = '0; in_data = '0;
    model_reset();
    do_reset(4'b0);
    do_reset(4'b0);

    chk("reset out_vld",  {31'b0, o_vld[0]},   32'h0);
    chk("reset out_data", o_data[0],           32'h0);
    chk("reset aligned",  {31'b0, o_align[0]}, 32'h0);
    chk("reset err_skew", {31'b0, o_eskew[0]}, 32'h0);
    chk("reset err_ovf",  {31'b0, o_eovf[0]},  32'h0);

    // Zero skew: B8, 01, 02 on all lanes in cycles 0..2.
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: tick(4'hF, rep4(8'hB8));
        1: tick(4'hF, rep4(8'h01));
        2: tick(4'hF, rep4(8'h02));
        default: tick(4'h0, 32'h0);
      endcase
      chk($sformatf("zs out_vld c%0d", c+1), {31'b0, o_vld[0]}, {31'b0, (c+1) >= 2 && (c+1) <= 4});
      chk($sformatf("zs aligned c%0d", c+1), {31'b0, o_align[0]}, {31'b0, (c+1) >= 2 && (c+1) <= 4});
      if (c+1 == 2) chk("zs word0", o_data[0], 32'hB8B8B8B8);
      if (c+1 == 3) chk("zs word1", o_data[0], 32'h01010101);
      if (c+1 >= 4) chk("zs word2/hold", o_data[0], 32'h02020202);
    end

    // Skew: lane0 at cycles 0..3, lanes 1..3 at cycles 3..6, bytes 10..13.
    do_reset(4'b0);
    for (int c = 0; c < 12; c++) begin
      v = 4'b0; d = '0;
      if (c <= 3) begin v[0] = 1'b1; d[7:0] = 8'h10 + 8'(c); end
      if (c >= 3 && c <= 6) begin
        v[3:1] = 3'b111;
        d[31:8] = {3{8'h10 + 8'(c-3)}};
      end
      tick(v, d);
      chk($sformatf("skew out_vld c%0d", c+1), {31'b0, o_vld[0]}, {31'b0, (c+1) >= 5 && (c+1) <= 8});
      chk($sformatf("skew aligned c%0d", c+1), {31'b0, o_align[0]}, {31'b0, (c+1) >= 5 && (c+1) <= 8});
      if ((c+1) >= 5 && (c+1) <= 8)
        chk($sformatf("skew word c%0d", c+1), o_data[0], rep4(8'h10 + 8'(c-4)));
    end

    // Timeout: lane2 alone for 10 cycles.
    do_reset(4'b0);
    nsk = 0; nv = 0;
    for (int c = 0; c < 30; c++) begin
      tick((c < 10) ? 4'b0100 : 4'b0000, {8'h0, 8'hE0 + 8'(c), 16'h0});
      if (o_eskew[0]) nsk++;
      if (o_vld[0]) nv++;
    end
    chk("timeout err_skew pulses", 32'(nsk), 32'd1);
    chk("timeout out_vld count", 32'(nv), 32'd0);
    tick(4'hF, rep4(8'hC3));
    tick(4'h0, 32'h0);
    chk("timeout fifos empty", o_data[0], 32'hC3C3C3C3);
    for (int c = 0; c < 3; c++) tick(4'h0, 32'h0);

    // Overflow on lane1.
    do_reset(4'b0);
    run_ovf(1'b1);

    // Reset in the middle of an aligned stream.
    do_reset(4'b0);
    for (int c = 0; c < 5; c++) tick(4'hF, $urandom);
    chk("midrst aligned before", {31'b0, o_align[0]}, 32'h1);
    do_reset(4'hF);
    chk("midrst out_vld", {31'b0, o_vld[0]}, 32'h0);
    chk("midrst aligned", {31'b0, o_align[0]}, 32'h0);
    nv = 0;
    for (int c = 0; c < 5; c++) begin
      tick(4'h0, 32'h0);
      if (o_vld[0] || o_align[0]) nv++;
    end
    chk("midrst no stale output", 32'(nv), 32'd0);

`ifdef CSI_ALIGN_STATS_EN
    do_reset(4'b0);
    for (int t = 0; t < 3; t++) run_timeout(1, 30);
    run_ovf(1'b0);
    run_ovf(1'b0);
    chk("stats skew_err_cnt dut0", {16'b0, o_scnt[0]}, 32'd3);
    chk("stats ovf_err_cnt dut0",  {16'b0, o_ocnt[0]}, 32'd2);
    chk("stats skew_err_cnt dut1", {16'b0, o_scnt[1]}, 32'd3);
    chk("stats ovf_err_cnt dut1",  {16'b0, o_ocnt[1]}, 32'd2);
    do_reset(4'b0);
    chk("stats skew clear", {16'b0, o_scnt[0]}, 32'd0);
    chk("stats ovf clear",  {16'b0, o_ocnt[0]}, 32'd0);
`endif

    // Randomized bursts with per-lane offsets, lengths and gaps.
    do_reset(4'b0);
    for (int b = 0; b < 40; b++) begin
      same = ($urandom_range(0, 2) == 0);
      span = 0;
      for (int i = 0; i < NL; i++) begin
        off[i] = same ? 0 : $urandom_range(0, 9);
        len[i] = same ? ((i == 0) ? $urandom_range(1, 14) : len[0]) : $urandom_range(1, 12);
        if (off[i] + len[i] > span) span = off[i] + len[i];
      end
      for (int c = 0; c < span + 30; c++) begin
        v = 4'b0;
        for (int i = 0; i < NL; i++)
          v[i] = (c >= off[i]) && (c < off[i] + len[i]) && (same || $urandom_range(0, 7) != 0);
        if ((b % 9 == 4) && (c == span / 2)) do_reset(v);
        else tick(v, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
